// File: rtl/ram_file.sv
// ram_file -- banked general-purpose register storage for a PIC16F628A-style core.
//
// Maps the resolved 9-bit file address onto 224 bytes of physical GPR storage:
//   bank0  0x020-0x06F          -> 0..79
//   common xx70-xx7F, any bank  -> 80..95 (mirrored in all four banks)
//   bank1  0x0A0-0x0EF          -> 96..175
//   bank2  0x120-0x14F          -> 176..223
// Every other address is non-GPR and belongs to the SFR block.
//
// Ports:
//   clk              in   core clock, rising edge
//   rst              in   asynchronous active-high reset
//   ram_file_address in   [8:0] resolved file address
//   wr_en            in   write strobe
//   wr_data          in   [7:0] write data
//   rd_data          out  [7:0] registered read data (1-cycle latency, read-before-write)
//   addr_is_gpr      out  combinational GPR hit for ram_file_address
//   init_busy        out  high while the post-reset clear sweep runs
module ram_file #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] ram_file_address,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       addr_is_gpr,
  output logic       init_busy
);

  localparam logic [7:0] LAST_IDX = 8'd223;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Decode a file address into {hit, physical index}. Index is 0 on a miss so
  // that a dropped access never points outside the array.
  function automatic logic [8:0] map_addr(input logic [8:0] a);
    logic [6:0] off;
    logic [7:0] idx;
    logic       hit;
    off = a[6:0];
    idx = 8'd0;
    hit = 1'b0;
    if (off[6:4] == 3'b111) begin
      // common area, same 16 bytes in every bank
      hit = 1'b1;
      idx = 8'd80 + {4'd0, off[3:0]};
    end else if (off >= 7'h20) begin
      // off is 0x20..0x6F here
      case (a[8:7])
        2'd0: begin
          hit = 1'b1;
          idx = {1'b0, off} - 8'd32;
        end
        2'd1: begin
          hit = 1'b1;
          idx = {1'b0, off} + 8'd64;
        end
        2'd2: begin
          if (off <= 7'h4F) begin
            hit = 1'b1;
            idx = {1'b0, off} + 8'd144;
          end else begin
            hit = 1'b0;
            idx = 8'd0;
          end
        end
        default: begin
          hit = 1'b0;
          idx = 8'd0;
        end
      endcase
    end else begin
      hit = 1'b0;
      idx = 8'd0;
    end
    return {hit, idx};
  endfunction

  logic [7:0] mem [0:223];

  state_t     state_q;
  logic [7:0] clr_idx_q;
  logic [7:0] rd_data_q;
  logic       init_busy_q;

  logic [8:0] map_s;
  logic [7:0] idx_s;
  logic       we_s;
  logic [7:0] we_idx_s;
  logic [7:0] we_data_s;

  // Address decode and memory write-port steering.
  always_comb begin
    map_s       = map_addr(ram_file_address);
    idx_s       = map_s[7:0];
    addr_is_gpr = map_s[8];
    we_s        = 1'b0;
    we_idx_s    = 8'd0;
    we_data_s   = 8'd0;
    if (state_q == ST_CLEAR) begin
      // sweep owns the write port; external writes are ignored
      we_s      = 1'b1;
      we_idx_s  = clr_idx_q;
      we_data_s = 8'd0;
    end else if (wr_en && map_s[8]) begin
      we_s      = 1'b1;
      we_idx_s  = idx_s;
      we_data_s = wr_data;
    end else begin
      we_s      = 1'b0;
      we_idx_s  = 8'd0;
      we_data_s = 8'd0;
    end
  end

  // Storage array: no reset, only the sweep clears it.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[we_idx_s] <= we_data_s;
    end
  end

  // Control FSM, sweep counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx_q   <= 8'd0;
      rd_data_q   <= 8'd0;
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      init_busy_q <= CLEAR_ON_RESET;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          rd_data_q <= 8'd0;
          if (clr_idx_q == LAST_IDX) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + 8'd1;
          end
        end
        ST_READY: begin
          init_busy_q <= 1'b0;
          // reads the pre-write contents, giving read-before-write
          rd_data_q <= addr_is_gpr ? mem[idx_s] : 8'd0;
        end
        default: begin
          state_q     <= ST_READY;
          init_busy_q <= 1'b0;
          rd_data_q   <= 8'd0;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_ram_file.sv
module tb_ram_file;

  logic       clk;
  logic       rst;
  logic [8:0] ram_file_address;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       addr_is_gpr;
  logic       init_busy;

  int tests  = 0;
  int failed = 0;

  ram_file #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .ram_file_address (ram_file_address),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .rd_data          (rd_data),
    .addr_is_gpr      (addr_is_gpr),
    .init_busy        (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference map written as plain full-address ranges.
  function automatic logic ref_gpr(input int a);
    return (a >= 'h020 && a <= 'h06F) || (a >= 'h0A0 && a <= 'h0EF) ||
           (a >= 'h120 && a <= 'h14F) ||
           (a >= 'h070 && a <= 'h07F) || (a >= 'h0F0 && a <= 'h0FF) ||
           (a >= 'h170 && a <= 'h17F) || (a >= 'h1F0 && a <= 'h1FF);
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic do_write(input logic [8:0] a, input logic [7:0] d);
    ram_file_address = a;
    wr_data = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [8:0] a, input logic [7:0] exp);
    ram_file_address = a;
    wr_en = 1'b0;
    @(negedge clk);
    check8(tag, rd_data, exp);
  endtask

  // Counts falling edges with init_busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int gpr_cnt;
    int zero_bad;
    rst = 1'b1;
    ram_file_address = 9'h000;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (2) @(negedge clk);
    check8("reset_rd_data", rd_data, 8'h00);
    check_int("reset_init_busy", int'(init_busy), 1);

    // 1. sweep length and cleared contents
    rst = 1'b0;
    count_busy(n);
    check_int("sweep_len", n, 224);
    zero_bad = 0;
    for (int a = 0; a < 512; a++) begin
      if (ref_gpr(a)) begin
        ram_file_address = a[8:0];
        @(negedge clk);
        if (rd_data !== 8'h00) zero_bad++;
      end
    end
    check_int("all_gpr_zero", zero_bad, 0);

    // 2. common-area mirror
    do_write(9'h075, 8'hA5);
    do_read("mirror_0F5", 9'h0F5, 8'hA5);
    do_read("mirror_175", 9'h175, 8'hA5);
    do_read("mirror_1F5", 9'h1F5, 8'hA5);
    do_read("mirror_075", 9'h075, 8'hA5);

    // 3. distinct banks, dropped non-GPR write
    do_write(9'h020, 8'h11);
    do_write(9'h0A0, 8'h22);
    do_read("bank0_020", 9'h020, 8'h11);
    do_read("bank1_0A0", 9'h0A0, 8'h22);
    ram_file_address = 9'h150;
    #1;
    check_int("gpr_150", int'(addr_is_gpr), 0);
    do_write(9'h150, 8'hFF);
    do_read("read_150", 9'h150, 8'h00);
    do_read("bank0_020_after_drop", 9'h020, 8'h11);
    do_write(9'h14F, 8'h5A);
    do_read("bank2_top_14F", 9'h14F, 8'h5A);
    do_read("bank0_bottom_06F", 9'h06F, 8'h00);

    // 4. read-before-write on 0x130
    ram_file_address = 9'h130;
    wr_data = 8'h3C;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check8("rbw_old", rd_data, 8'h00);
    @(negedge clk);
    check8("rbw_new", rd_data, 8'h3C);

    // 5. reset mid-sweep restarts the sweep and drops writes
    do_write(9'h040, 8'h55);
    do_read("pre_reset_040", 9'h040, 8'h55);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check_int("busy_mid_sweep", int'(init_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ram_file_address = 9'h075;
    @(negedge clk);
    check8("rd_held_in_clear", rd_data, 8'h00);
    do_write(9'h040, 8'h77);
    count_busy(n);
    check_int("sweep_len_restart", n, 224 - 2);
    do_read("post_sweep_040", 9'h040, 8'h00);
    do_read("post_sweep_075", 9'h075, 8'h00);
    do_write(9'h040, 8'h77);
    do_read("ready_write_040", 9'h040, 8'h77);

    // 6. addr_is_gpr across the full address space
    zero_bad = 0;
    gpr_cnt = 0;
    for (int a = 0; a < 512; a++) begin
      ram_file_address = a[8:0];
      #1;
      if (addr_is_gpr !== ref_gpr(a)) zero_bad++;
      if (addr_is_gpr === 1'b1) gpr_cnt++;
    end
    check_int("gpr_map_mismatches", zero_bad, 0);
    check_int("gpr_count", gpr_cnt, 272);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
